// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: arbitrates two burst-oriented pixel writers onto a single
// framebuffer write port. Ownership is granted per burst with round-robin
// tie-breaking. The write port is driven one cycle after each accepted beat.
// Out-of-range beats and stalled bursts raise sticky error flags.
module fb_write_arbiter #(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8,
  parameter int FB_SIZE = 19200,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  input  logic              r0_last,
  output logic              r0_ready,
  input  logic              r1_valid,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  input  logic              r1_last,
  output logic              r1_ready,
  input  logic              hold,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [ADDR_W-1:0] wr_count,
  output logic              err_oob,
  output logic              err_timeout
);

  // state | meaning
  // IDLE  | no owner; a new grant is decided here unless hold is high
  // OWN0  | requester 0 owns the write port until its last beat or timeout
  // OWN1  | requester 1 owns the write port until its last beat or timeout
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  // The idle counter only has to reach TIMEOUT-1: the TIMEOUT-th idle cycle
  // is the one that releases ownership.
  localparam int               CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] IDLE_TC = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]  FB_LIM  = (ADDR_W + 1)'(FB_SIZE);

  state_t            state_q, state_d;
  logic              pri_q, pri_d;           // 1: requester 1 wins a tie
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] wraddr_q, wraddr_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;
  logic [ADDR_W-1:0] wr_count_q, wr_count_d;
  logic              err_oob_q, err_oob_d;
  logic              err_tmo_q, err_tmo_d;

  logic              acc0, acc1, acc, acc_last, in_range, tmo_hit;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;

  // Beat acceptance and selection of the current owner's payload
  always_comb begin
    acc0     = r0_valid && (state_q == OWN0);
    acc1     = r1_valid && (state_q == OWN1);
    acc      = acc0 || acc1;
    acc_addr = acc1 ? r1_addr : r0_addr;
    acc_data = acc1 ? r1_data : r0_data;
    acc_last = acc1 ? r1_last : r0_last;
    in_range = ({1'b0, acc_addr} < FB_LIM);
    tmo_hit  = (state_q != IDLE) && !acc && (idle_cnt_q == IDLE_TC);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: round-robin grant from IDLE, release on last beat or timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!hold) begin
          if (r0_valid && r1_valid) state_d = pri_q ? OWN1 : OWN0;
          else if (r0_valid)        state_d = OWN0;
          else if (r1_valid)        state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if ((acc && acc_last) || tmo_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    grant    = {state_q == OWN1, state_q == OWN0};
    busy     = (state_q != IDLE);
    r0_ready = (state_q == OWN0);
    r1_ready = (state_q == OWN1);
  end

  // Next values for priority pointer, idle counter, write stage, flags
  always_comb begin
    pri_d = pri_q;
    if (state_q == IDLE && state_d == OWN0)      pri_d = 1'b1;
    else if (state_q == IDLE && state_d == OWN1) pri_d = 1'b0;

    idle_cnt_d = (state_q == IDLE || acc || tmo_hit) ? '0 : idle_cnt_q + 1'b1;

    wren_d     = acc && in_range;
    wraddr_d   = wren_d ? acc_addr : wraddr_q;
    wrdata_d   = wren_d ? acc_data : wrdata_q;
    wr_count_d = wr_count_q + ADDR_W'(wren_q);

    // A set event in the same cycle as err_clr keeps the flag high
    err_oob_d  = (acc && !in_range) || (err_oob_q && !err_clr);
    err_tmo_d  = tmo_hit || (err_tmo_q && !err_clr);
  end

  // Registers for pointer, counter, write stage and flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pri_q      <= 1'b0;
      idle_cnt_q <= '0;
      wren_q     <= 1'b0;
      wraddr_q   <= '0;
      wrdata_q   <= '0;
      wr_count_q <= '0;
      err_oob_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      pri_q      <= pri_d;
      idle_cnt_q <= idle_cnt_d;
      wren_q     <= wren_d;
      wraddr_q   <= wraddr_d;
      wrdata_q   <= wrdata_d;
      wr_count_q <= wr_count_d;
      err_oob_q  <= err_oob_d;
      err_tmo_q  <= err_tmo_d;
    end
  end

  assign ram_wren    = wren_q;
  assign ram_wraddr  = wraddr_q;
  assign ram_data    = wrdata_q;
  assign wr_count    = wr_count_q;
  assign err_oob     = err_oob_q;
  assign err_timeout = err_tmo_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Testbench for fb_write_arbiter: inputs change and outputs are sampled on the
// falling clock edge. Expected writes go into a scoreboard queue when a beat
// is driven, and are compared against the writes seen on the RAM port.
module tb_fb_write_arbiter;
  localparam int AW = 19;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          r0_valid = 1'b0, r0_last = 1'b0, r1_valid = 1'b0, r1_last = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_data = '0, r1_data = '0;
  logic          hold = 1'b0, err_clr = 1'b0;
  logic          r0_ready, r1_ready, ram_wren, busy, err_oob, err_timeout;
  logic [AW-1:0] ram_wraddr, wr_count;
  logic [DW-1:0] ram_data;
  logic [1:0]    grant;

  fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_SIZE(19200), .TIMEOUT(1024)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_last(r0_last), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_last(r1_last), .r1_ready(r1_ready),
    .hold(hold), .err_clr(err_clr),
    .ram_wraddr(ram_wraddr), .ram_data(ram_data), .ram_wren(ram_wren),
    .grant(grant), .busy(busy), .wr_count(wr_count),
    .err_oob(err_oob), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  checks = 0;
  int  failures = 0;

  // Record every write seen on the RAM port
  always @(negedge clk) begin
    if (ram_wren === 1'b1) begin
      wr_t w;
      w.addr = ram_wraddr; w.data = ram_data; w.cyc = cyc;
      obs_q.push_back(w);
    end
  end

  // Beat driven now is accepted at the next rising edge; its write is
  // expected during the cycle after that edge.
  task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.addr = a; w.data = d; w.cyc = cyc + 1;
    exp_q.push_back(w);
  endtask

  task automatic idle_inputs();
    r0_valid = 0; r0_last = 0; r1_valid = 0; r1_last = 0;
    hold = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    reset = 1;
  endtask

  task automatic test_reset();
    wr_t e, o;
    reset = 0;
    r0_valid = 1; r0_addr = 19'd9; r0_data = 8'h99; r0_last = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0 || r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl got grant=%b busy=%b rdy=%b%b exp 00 0 00", grant, busy, r1_ready, r0_ready);
    end
    checks++;
    if (ram_wren !== 1'b0 || ram_wraddr !== '0 || ram_data !== '0) begin
      failures++; $display("FAIL reset_ram got wren=%b addr=%0d data=%0h exp 0 0 0", ram_wren, ram_wraddr, ram_data);
    end
    checks++;
    if (wr_count !== '0 || err_oob !== 1'b0 || err_timeout !== 1'b0) begin
      failures++; $display("FAIL reset_stat got cnt=%0d oob=%b tmo=%b exp 0 0 0", wr_count, err_oob, err_timeout);
    end
    reset = 1;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin
      failures++; $display("FAIL reset_first_grant got=%b exp=01", grant);
    end
    expect_write(19'd9, 8'h99);
    @(negedge clk);
    r0_valid = 0; r0_last = 0;
    @(negedge clk);
    checks++;
    if (obs_q.size() != 1) begin
      failures++; $display("FAIL reset_sb_count got=%0d exp=1", obs_q.size());
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
        failures++; $display("FAIL reset_sb got a=%0d d=%0h c=%0d exp a=%0d d=%0h c=%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
      end
    end
  endtask

  task automatic test_single_burst();
    wr_t e, o;
    do_reset();
    r0_valid = 1; r0_addr = 0; r0_data = 8'h10; r0_last = 0;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || busy !== 1'b1 || r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      failures++; $display("FAIL single_grant got grant=%b busy=%b rdy=%b%b exp 01 1 01", grant, busy, r1_ready, r0_ready);
    end
    for (int i = 0; i < 4; i++) begin
      r0_addr = AW'(i); r0_data = DW'(8'h10 + i); r0_last = (i == 3);
      expect_write(AW'(i), DW'(8'h10 + i));
      @(negedge clk);
    end
    r0_valid = 0; r0_last = 0;
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      failures++; $display("FAIL single_release got grant=%b busy=%b exp 00 0", grant, busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (ram_wren !== 1'b0 || wr_count !== 19'd4) begin
      failures++; $display("FAIL single_count got wren=%b cnt=%0d exp 0 4", ram_wren, wr_count);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL single_sb_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
        failures++; $display("FAIL single_sb got a=%0d d=%0h c=%0d exp a=%0d d=%0h c=%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
      end
    end
  endtask

  task automatic test_contention();
    wr_t e, o;
    do_reset();
    r0_valid = 1; r0_addr = 19'd100; r0_data = 8'h01; r0_last = 0;
    r1_valid = 1; r1_addr = 19'd200; r1_data = 8'h55; r1_last = 1;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || r1_ready !== 1'b0) begin
      failures++; $display("FAIL cont_first got grant=%b r1_ready=%b exp 01 0", grant, r1_ready);
    end
    expect_write(19'd100, 8'h01);
    @(negedge clk);
    r0_addr = 19'd101; r0_data = 8'h02; r0_last = 1;
    expect_write(19'd101, 8'h02);
    @(negedge clk);
    r0_valid = 0; r0_last = 0;
    checks++;
    if (grant !== 2'b00 || r1_ready !== 1'b0) begin
      failures++; $display("FAIL cont_gap got grant=%b r1_ready=%b exp 00 0", grant, r1_ready);
    end
    @(negedge clk);
    checks++;
    if (grant !== 2'b10 || r1_ready !== 1'b1 || r0_ready !== 1'b0) begin
      failures++; $display("FAIL cont_second got grant=%b rdy=%b%b exp 10 10", grant, r1_ready, r0_ready);
    end
    expect_write(19'd200, 8'h55);
    @(negedge clk);
    r0_valid = 1; r0_addr = 19'd102; r0_data = 8'h03; r0_last = 1;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin
      failures++; $display("FAIL cont_rr_back got grant=%b exp=01", grant);
    end
    expect_write(19'd102, 8'h03);
    @(negedge clk);
    r0_valid = 0; r1_valid = 0; r0_last = 0; r1_last = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL cont_sb_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
        failures++; $display("FAIL cont_sb got a=%0d d=%0h c=%0d exp a=%0d d=%0h c=%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
      end
    end
  endtask

  task automatic test_bounds();
    wr_t e, o;
    do_reset();
    r1_valid = 1; r1_addr = 19'd19199; r1_data = 8'hAA; r1_last = 0;
    @(negedge clk);
    expect_write(19'd19199, 8'hAA);
    @(negedge clk);
    r1_addr = 19'd19200; r1_data = 8'hBB; r1_last = 1;
    checks++;
    if (err_oob !== 1'b0) begin
      failures++; $display("FAIL bounds_pre got err_oob=%b exp=0", err_oob);
    end
    @(negedge clk);
    r1_valid = 0; r1_last = 0;
    checks++;
    if (err_oob !== 1'b1 || ram_wren !== 1'b0 || grant !== 2'b00) begin
      failures++; $display("FAIL bounds_oob got oob=%b wren=%b grant=%b exp 1 0 00", err_oob, ram_wren, grant);
    end
    @(negedge clk);
    checks++;
    if (wr_count !== 19'd1 || err_oob !== 1'b1) begin
      failures++; $display("FAIL bounds_count got cnt=%0d oob=%b exp 1 1", wr_count, err_oob);
    end
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    checks++;
    if (err_oob !== 1'b0) begin
      failures++; $display("FAIL bounds_clr got err_oob=%b exp=0", err_oob);
    end
    r1_valid = 1; r1_addr = 19'd20000; r1_data = 8'hCC; r1_last = 1;
    @(negedge clk);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0; r1_valid = 0; r1_last = 0;
    checks++;
    if (err_oob !== 1'b1 || wr_count !== 19'd1) begin
      failures++; $display("FAIL bounds_set_wins got oob=%b cnt=%0d exp 1 1", err_oob, wr_count);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL bounds_sb_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
        failures++; $display("FAIL bounds_sb got a=%0d d=%0h c=%0d exp a=%0d d=%0h c=%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
      end
    end
  endtask

  task automatic test_timeout();
    wr_t e, o;
    do_reset();
    r0_valid = 1; r0_addr = 19'd5; r0_data = 8'h5A; r0_last = 0;
    @(negedge clk);
    expect_write(19'd5, 8'h5A);
    @(negedge clk);
    r0_valid = 0;
    repeat (1023) @(negedge clk);
    checks++;
    if (grant !== 2'b01 || err_timeout !== 1'b0) begin
      failures++; $display("FAIL tmo_early got grant=%b tmo=%b exp 01 0", grant, err_timeout);
    end
    @(negedge clk);
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0 || err_timeout !== 1'b1) begin
      failures++; $display("FAIL tmo_fire got grant=%b busy=%b tmo=%b exp 00 0 1", grant, busy, err_timeout);
    end
    r0_valid = 1; r0_last = 1;
    r1_valid = 1; r1_addr = 19'd7; r1_data = 8'h77; r1_last = 1;
    @(negedge clk);
    checks++;
    if (grant !== 2'b10 || err_timeout !== 1'b1) begin
      failures++; $display("FAIL tmo_rr got grant=%b tmo=%b exp 10 1", grant, err_timeout);
    end
    expect_write(19'd7, 8'h77);
    @(negedge clk);
    r0_valid = 0; r1_valid = 0; r0_last = 0; r1_last = 0;
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++; $display("FAIL tmo_clr got tmo=%b exp=0", err_timeout);
    end
    @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL tmo_sb_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
        failures++; $display("FAIL tmo_sb got a=%0d d=%0h c=%0d exp a=%0d d=%0h c=%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
      end
    end
  endtask

  task automatic test_hold();
    wr_t e, o;
    int bad;
    do_reset();
    hold = 1; r1_valid = 1; r1_addr = 19'd300; r1_data = 8'h30; r1_last = 1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (grant !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL hold_block got bad_cycles=%0d exp=0", bad);
    end
    hold = 0;
    @(negedge clk);
    checks++;
    if (grant !== 2'b10) begin
      failures++; $display("FAIL hold_release got grant=%b exp=10", grant);
    end
    expect_write(19'd300, 8'h30);
    @(negedge clk);
    r1_valid = 0; r1_last = 0;
    r0_valid = 1; r0_addr = 19'd310; r0_data = 8'h31; r0_last = 0;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (grant !== 2'b01) bad++;
      r0_addr = AW'(310 + i); r0_data = DW'(8'h31 + i); r0_last = (i == 2);
      if (i == 1) hold = 1;
      expect_write(AW'(310 + i), DW'(8'h31 + i));
      @(negedge clk);
    end
    checks++;
    if (bad != 0 || grant !== 2'b00) begin
      failures++; $display("FAIL hold_midburst got bad_cycles=%0d grant=%b exp 0 00", bad, grant);
    end
    r0_last = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (grant !== 2'b00) begin
      failures++; $display("FAIL hold_after got grant=%b exp=00", grant);
    end
    r0_valid = 0; hold = 0;
    @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL hold_sb_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
        failures++; $display("FAIL hold_sb got a=%0d d=%0h c=%0d exp a=%0d d=%0h c=%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    wr_t e, o;
    do_reset();
    r0_valid = 1; r0_addr = 19'd400; r0_data = 8'h40; r0_last = 0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      r0_addr = AW'(400 + i); r0_data = DW'(8'h40 + i);
      expect_write(AW'(400 + i), DW'(8'h40 + i));
      @(negedge clk);
    end
    r0_addr = 19'd402; r0_data = 8'h42;
    #2 reset = 0;
    #1;
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0 || r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
      failures++; $display("FAIL midrst_ctrl got grant=%b busy=%b rdy=%b%b exp 00 0 00", grant, busy, r1_ready, r0_ready);
    end
    checks++;
    if (ram_wren !== 1'b0 || ram_wraddr !== '0 || ram_data !== '0 || wr_count !== '0) begin
      failures++; $display("FAIL midrst_ram got wren=%b addr=%0d data=%0h cnt=%0d exp 0 0 0 0", ram_wren, ram_wraddr, ram_data, wr_count);
    end
    @(negedge clk);
    reset = 1; r0_valid = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_count !== '0 || grant !== 2'b00) begin
      failures++; $display("FAIL midrst_after got cnt=%0d grant=%b exp 0 00", wr_count, grant);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL midrst_sb_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
        failures++; $display("FAIL midrst_sb got a=%0d d=%0h c=%0d exp a=%0d d=%0h c=%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_contention();
    test_bounds();
    test_timeout();
    test_hold();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
